// File: rtl/lab2_proc_imul_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lab2_proc_imul_arbiter
// Brief    : Val/rdy arbiter sharing one iterative multiplier among
//            p_num_reqs requesters, one transaction in flight. Round-robin
//            by default; LAB2_PROC_IMUL_ARBITER_FIXED_PRIO_EN selects fixed
//            priority with requester 0 highest.
// Revision : 1.0
// ============================================================================
module lab2_proc_imul_arbiter #(
    parameter int unsigned p_num_reqs = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_num_reqs-1:0]         req_val_i,
    output logic [p_num_reqs-1:0]         req_rdy_o,
    input  logic [64*p_num_reqs-1:0]      req_msg_i,
    output logic [p_num_reqs-1:0]         resp_val_o,
    input  logic [p_num_reqs-1:0]         resp_rdy_i,
    output logic [32*p_num_reqs-1:0]      resp_msg_o,
    output logic                          imul_req_val_o,
    input  logic                          imul_req_rdy_i,
    output logic [63:0]                   imul_req_msg_o,
    input  logic                          imul_resp_val_i,
    output logic                          imul_resp_rdy_o,
    input  logic [31:0]                   imul_resp_msg_i,
    output logic                          busy_o,
    output logic [$clog2(p_num_reqs)-1:0] owner_o
);

    localparam int unsigned c_ptr_w = $clog2(p_num_reqs);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             state_q;
    logic [c_ptr_w-1:0] owner_q;
    logic [c_ptr_w-1:0] scan_base;
    logic [c_ptr_w-1:0] grant;
    logic [31:0]        idx;
    logic               any_val;
    logic               req_fire;
    logic               resp_fire;

    assign any_val   = |req_val_i;
    assign req_fire  = (state_q == IDLE) && any_val && imul_req_rdy_i;
    assign resp_fire = (state_q == WAIT) && imul_resp_val_i && resp_rdy_i[owner_q];

`ifdef LAB2_PROC_IMUL_ARBITER_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [c_ptr_w-1:0] ptr_q;
    logic [c_ptr_w-1:0] ptr_d;

    assign scan_base = ptr_q;
    assign ptr_d     = (grant == c_ptr_w'(p_num_reqs - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (req_fire) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Scan from scan_base upward with wrap; walking downward lets the
    // nearest valid requester be the last (winning) assignment.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = int'(p_num_reqs) - 1; k >= 0; k--) begin
            idx = {{(32-c_ptr_w){1'b0}}, scan_base} + 32'(k);
            if (idx >= p_num_reqs) begin
                idx = idx - p_num_reqs;
            end
            if (req_val_i[idx[c_ptr_w-1:0]]) begin
                grant = idx[c_ptr_w-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        state_q <= WAIT;
                        owner_q <= grant;
                    end
                end
                WAIT: begin
                    if (resp_fire) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshakes are steered combinationally so arbitration adds no latency.
    always_comb begin
        req_rdy_o       = '0;
        resp_val_o      = '0;
        imul_req_val_o  = 1'b0;
        imul_req_msg_o  = '0;
        imul_resp_rdy_o = 1'b0;
        if (!reset) begin
            if (state_q == IDLE) begin
                imul_req_val_o = any_val;
                if (any_val) begin
                    req_rdy_o[grant] = imul_req_rdy_i;
                    for (int i = 0; i < int'(p_num_reqs); i++) begin
                        if (c_ptr_w'(i) == grant) begin
                            imul_req_msg_o = req_msg_i[64*i +: 64];
                        end
                    end
                end
            end else begin
                resp_val_o[owner_q] = imul_resp_val_i;
                imul_resp_rdy_o     = resp_rdy_i[owner_q];
            end
        end
    end

    assign resp_msg_o = {p_num_reqs{imul_resp_msg_i}};
    assign busy_o     = (state_q == WAIT) && !reset;
    assign owner_o    = owner_q;

endmodule

`default_nettype wire
